// File: rtl/fp_add_seq.sv
// rtl/fp_add_seq.sv - multi-cycle binary32 add/subtract; `FP_ADD_FAST_ALIGN_EN selects a one-cycle barrel aligner
module fp_add_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op_sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        flag_nv,
   output logic        flag_of,
   output logic        flag_nx
);

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        sign_q, sign_d, eff_sub_q, eff_sub_d;
   logic [8:0]  exp_q, exp_d;
   logic [26:0] big_q, big_d, small_q, small_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [27:0] sum_q, sum_d;
   logic [31:0] result_q, result_d;
   logic        nv_q, nv_d, of_q, of_d, nx_q, nx_d;

   // Operand classification, taken from the captured operands (b already sign-adjusted)
   logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap;
   logic [31:0] big_w, small_w;
   logic [7:0]  big_exp_eff, small_exp_eff, diff;
   logic [4:0]  align_cnt;

   assign a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
   assign b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
   assign a_snan = a_nan & ~a_q[22];
   assign b_snan = b_nan & ~b_q[22];
   assign a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
   assign b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
   assign swap   = b_q[30:0] > a_q[30:0];
   assign big_w  = swap ? b_q : a_q;
   assign small_w = swap ? a_q : b_q;
   assign big_exp_eff   = (big_w[30:23] == 8'd0) ? 8'd1 : big_w[30:23];
   assign small_exp_eff = (small_w[30:23] == 8'd0) ? 8'd1 : small_w[30:23];
   assign diff      = big_exp_eff - small_exp_eff;
   assign align_cnt = (diff > 8'd27) ? 5'd27 : diff[4:0];

   // Round-to-nearest-even on the normalized sum: mantissa in [26:3], G/R/S in [2:0]
   logic [23:0] mant;
   logic        rnd_g, rnd_rs, rnd_up, hidden;
   logic [24:0] mant_r;
   logic [8:0]  exp_r;
   logic [22:0] frac_r;

   assign mant   = sum_q[26:3];
   assign rnd_g  = sum_q[2];
   assign rnd_rs = sum_q[1] | sum_q[0];
   assign rnd_up = rnd_g & (rnd_rs | mant[0]);
   assign mant_r = {1'b0, mant} + {24'd0, rnd_up};
   assign exp_r  = exp_q + {8'd0, mant_r[24]};
   assign frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
   assign hidden = mant_r[24] | mant_r[23];

`ifdef FP_ADD_FAST_ALIGN_EN
   logic [26:0] fast_sh, fast_mask, fast_aligned;
   assign fast_sh      = small_q >> cnt_q;
   assign fast_mask    = (27'd1 << cnt_q) - 27'd1;
   assign fast_aligned = {fast_sh[26:1], fast_sh[0] | (|(small_q & fast_mask))};
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sign_d    = sign_q;
      eff_sub_d = eff_sub_q;
      exp_d     = exp_q;
      big_d     = big_q;
      small_d   = small_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      result_d  = result_q;
      nv_d      = nv_q;
      of_d      = of_q;
      nx_d      = nx_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = {b[31] ^ op_sub, b[30:0]};
               state_d = S_UNPACK;
            end
         end
         S_UNPACK: begin
            nv_d = 1'b0;
            of_d = 1'b0;
            nx_d = 1'b0;
            if (a_nan | b_nan) begin
               result_d = 32'h7FC0_0000;
               nv_d     = a_snan | b_snan;
               state_d  = S_DONE;
            end else if (a_inf & b_inf & (a_q[31] != b_q[31])) begin
               result_d = 32'h7FC0_0000;
               nv_d     = 1'b1;
               state_d  = S_DONE;
            end else if (a_inf) begin
               result_d = a_q;
               state_d  = S_DONE;
            end else if (b_inf) begin
               result_d = b_q;
               state_d  = S_DONE;
            end else begin
               sign_d    = big_w[31];
               eff_sub_d = a_q[31] ^ b_q[31];
               exp_d     = {1'b0, big_exp_eff};
               big_d     = {|big_w[30:23], big_w[22:0], 3'b000};
               small_d   = {|small_w[30:23], small_w[22:0], 3'b000};
               cnt_d     = align_cnt;
               state_d   = S_ALIGN;
            end
         end
         S_ALIGN: begin
`ifdef FP_ADD_FAST_ALIGN_EN
            small_d = fast_aligned;
            cnt_d   = 5'd0;
            state_d = S_ADD;
`else
            // Sticky bit collects everything shifted past position 0
            if (cnt_q != 5'd0) begin
               small_d = {1'b0, small_q[26:2], small_q[1] | small_q[0]};
               cnt_d   = cnt_q - 5'd1;
            end
            if (cnt_q <= 5'd1)
               state_d = S_ADD;
`endif
         end
         S_ADD: begin
            sum_d   = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                : ({1'b0, big_q} + {1'b0, small_q});
            state_d = S_NORM;
         end
         S_NORM: begin
            if (sum_q[27]) begin
               sum_d   = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
               exp_d   = exp_q + 9'd1;
               state_d = S_ROUND;
            end else if (!sum_q[26] && sum_q != 28'd0 && exp_q > 9'd1) begin
               sum_d = {sum_q[26:0], 1'b0};
               exp_d = exp_q - 9'd1;
               if (sum_q[25] || exp_q == 9'd2)
                  state_d = S_ROUND;
            end else begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            nv_d    = 1'b0;
            state_d = S_DONE;
            if (sum_q == 28'd0) begin
               result_d = {sign_q & ~eff_sub_q, 31'd0};
               of_d     = 1'b0;
               nx_d     = 1'b0;
            end else if (exp_r >= 9'd255) begin
               result_d = {sign_q, 8'hFF, 23'd0};
               of_d     = 1'b1;
               nx_d     = 1'b1;
            end else begin
               result_d = {sign_q, hidden ? exp_r[7:0] : 8'h00, frac_r};
               of_d     = 1'b0;
               nx_d     = rnd_g | rnd_rs;
            end
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         sign_q    <= 1'b0;
         eff_sub_q <= 1'b0;
         exp_q     <= 9'd0;
         big_q     <= 27'd0;
         small_q   <= 27'd0;
         cnt_q     <= 5'd0;
         sum_q     <= 28'd0;
         result_q  <= 32'd0;
         nv_q      <= 1'b0;
         of_q      <= 1'b0;
         nx_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sign_q    <= sign_d;
         eff_sub_q <= eff_sub_d;
         exp_q     <= exp_d;
         big_q     <= big_d;
         small_q   <= small_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         result_q  <= result_d;
         nv_q      <= nv_d;
         of_q      <= of_d;
         nx_q      <= nx_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign flag_nv   = nv_q;
   assign flag_of   = of_q;
   assign flag_nx   = nx_q;

endmodule
